// File: rtl/stream_width_downsizer.sv
// ============================================================================
// stream_width_downsizer : splits one wide AXI-Stream beat into RATIO narrow
// beats, least-significant slice first; TLAST/TDEST ride along.  Rev 1.0
// ============================================================================
`default_nettype none

module stream_width_downsizer #(
  parameter int OUT_WIDTH  = 32,
  parameter int RATIO      = 4,
  parameter int DEST_WIDTH = 4
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  input  logic                       in_tvalid,
  output logic                       in_tready,
  input  logic [OUT_WIDTH*RATIO-1:0] in_tdata,
  input  logic                       in_tlast,
  input  logic [DEST_WIDTH-1:0]      in_tdest,
  output logic                       out_tvalid,
  input  logic                       out_tready,
  output logic [OUT_WIDTH-1:0]       out_tdata,
  output logic                       out_tlast,
  output logic [DEST_WIDTH-1:0]      out_tdest
);

  localparam int                   c_IN_WIDTH  = OUT_WIDTH * RATIO;
  localparam int                   c_IDX_W     = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [c_IDX_W-1:0]   c_LAST_IDX  = c_IDX_W'(RATIO - 1);
  localparam logic [0:0]           c_EMPTY     = 1'b0;
  localparam logic [0:0]           c_SERIALIZE = 1'b1;

  logic [0:0]            r_state;
  logic [0:0]            w_state_nxt;
  logic [c_IDX_W-1:0]    r_idx;
  logic [c_IDX_W-1:0]    w_idx_nxt;
  logic [c_IN_WIDTH-1:0] r_hold_data;
  logic                  r_hold_last;
  logic [DEST_WIDTH-1:0] r_hold_dest;
  logic                  w_hold_valid;
  logic                  w_last_slice;
  logic                  w_in_hs;
  logic                  w_out_hs;
  logic [OUT_WIDTH-1:0]  w_slice;

  assign w_hold_valid = (r_state == c_SERIALIZE);
  assign w_last_slice = (r_idx == c_LAST_IDX);
  assign w_in_hs      = in_tvalid && in_tready;
  assign w_out_hs     = out_tvalid && out_tready;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= c_EMPTY;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Payload needs no reset: it is only observed while r_state is SERIALIZE.
  always_ff @(posedge ACLK) begin
    if (w_in_hs) begin
      r_hold_data <= in_tdata;
      r_hold_last <= in_tlast;
      r_hold_dest <= in_tdest;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      c_EMPTY: begin
        if (w_in_hs) begin
          w_state_nxt = c_SERIALIZE;
          w_idx_nxt   = '0;
        end
      end
      c_SERIALIZE: begin
        if (w_out_hs) begin
          if (!w_last_slice) begin
            w_idx_nxt = r_idx + c_IDX_W'(1);
          end else if (w_in_hs) begin
            // Reload on the final slice so the narrow side sees no bubble.
            w_idx_nxt = '0;
          end else begin
            w_state_nxt = c_EMPTY;
            w_idx_nxt   = '0;
          end
        end
      end
      default: begin
        w_state_nxt = c_EMPTY;
        w_idx_nxt   = '0;
      end
    endcase
  end

  generate
    if (RATIO == 1) begin : g_single
      assign w_slice = r_hold_data;
    end else begin : g_multi
      logic [OUT_WIDTH-1:0] w_slices [RATIO];
      for (genvar g = 0; g < RATIO; g++) begin : g_slice
        assign w_slices[g] = r_hold_data[g*OUT_WIDTH +: OUT_WIDTH];
      end
      assign w_slice = w_slices[r_idx];
    end
  endgenerate

  always_comb begin
    in_tready  = !w_hold_valid || (out_tready && w_last_slice);
    out_tvalid = w_hold_valid;
    out_tdata  = w_slice;
    out_tlast  = w_hold_valid && r_hold_last && w_last_slice;
    out_tdest  = r_hold_dest;
  end

endmodule

`default_nettype wire

// File: tb/tb_stream_width_downsizer.sv
// ============================================================================
// tb_stream_width_downsizer : directed vectors plus scoreboarded random traffic
// for the 4:1 and 1:1 configurations.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_stream_width_downsizer;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  always #5 ACLK = ~ACLK;

  logic        a_in_tvalid, a_in_tready, a_in_tlast;
  logic [31:0] a_in_tdata;
  logic [3:0]  a_in_tdest;
  logic        a_out_tvalid, a_out_tready, a_out_tlast;
  logic [7:0]  a_out_tdata;
  logic [3:0]  a_out_tdest;

  logic        b_in_tvalid, b_in_tready, b_in_tlast;
  logic [31:0] b_in_tdata;
  logic [3:0]  b_in_tdest;
  logic        b_out_tvalid, b_out_tready, b_out_tlast;
  logic [31:0] b_out_tdata;
  logic [3:0]  b_out_tdest;

  stream_width_downsizer #(.OUT_WIDTH(8), .RATIO(4), .DEST_WIDTH(4)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .in_tvalid(a_in_tvalid), .in_tready(a_in_tready), .in_tdata(a_in_tdata),
    .in_tlast(a_in_tlast), .in_tdest(a_in_tdest),
    .out_tvalid(a_out_tvalid), .out_tready(a_out_tready), .out_tdata(a_out_tdata),
    .out_tlast(a_out_tlast), .out_tdest(a_out_tdest)
  );

  stream_width_downsizer #(.OUT_WIDTH(32), .RATIO(1), .DEST_WIDTH(4)) dut1 (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .in_tvalid(b_in_tvalid), .in_tready(b_in_tready), .in_tdata(b_in_tdata),
    .in_tlast(b_in_tlast), .in_tdest(b_in_tdest),
    .out_tvalid(b_out_tvalid), .out_tready(b_out_tready), .out_tdata(b_out_tdata),
    .out_tlast(b_out_tlast), .out_tdest(b_out_tdest)
  );

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        il;
    logic [3:0]  idst;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [7:0]  e_od;
    logic        e_ol;
    logic [3:0]  e_odst;
  } vec_t;

  vec_t        vecs[$];
  int          n_pass  = 0;
  int          n_total = 0;

  logic [7:0]  q_data[$];
  logic        q_last[$];
  logic [3:0]  q_dest[$];
  int          accepted;
  int          cycles;
  bit          pending;
  logic        exp_ir;
  logic [31:0] beat;

  task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic void addv(input logic iv, input logic [31:0] id, input logic il,
                               input logic [3:0] idst, input logic ordy, input logic e_ir,
                               input logic e_ov, input logic [7:0] e_od, input logic e_ol,
                               input logic [3:0] e_odst);
    vec_t v;
    v.iv = iv; v.id = id; v.il = il; v.idst = idst; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_ol = e_ol; v.e_odst = e_odst;
    vecs.push_back(v);
  endfunction

  // Observe the 4:1 outputs as one word; data/dest only matter while valid.
  function automatic logic [14:0] pack_a(input logic ir, input logic ov, input logic ol,
                                         input logic [3:0] dst, input logic [7:0] d);
    return {ir, ov, ol, ov ? dst : 4'h0, ov ? d : 8'h00};
  endfunction

  task automatic a_expect(input string name, input logic ov, input logic [7:0] d,
                          input logic ol, input logic [3:0] dst);
    logic [14:0] act, exp;
    act = {1'b0, a_out_tvalid, a_out_tlast, a_out_tvalid ? a_out_tdest : 4'h0,
           a_out_tvalid ? a_out_tdata : 8'h00};
    exp = {1'b0, ov, ol, ov ? dst : 4'h0, ov ? d : 8'h00};
    chk(name, act == exp, 64'(act), 64'(exp));
  endtask

  initial begin
    ARESETn = 1'b0;
    a_in_tvalid = 0; a_in_tdata = '0; a_in_tlast = 0; a_in_tdest = '0; a_out_tready = 0;
    b_in_tvalid = 0; b_in_tdata = '0; b_in_tlast = 0; b_in_tdest = '0; b_out_tready = 1;

    // Single beat, back-to-back beats, stalled output, stall on the final slice.
    addv(1, 32'h44332211, 1, 3, 1,  1, 0, 8'h00, 0, 0);
    addv(0, 32'h0,        0, 0, 1,  0, 1, 8'h11, 0, 3);
    addv(0, 32'h0,        0, 0, 1,  0, 1, 8'h22, 0, 3);
    addv(0, 32'h0,        0, 0, 1,  0, 1, 8'h33, 0, 3);
    addv(0, 32'h0,        0, 0, 1,  1, 1, 8'h44, 1, 3);
    addv(0, 32'h0,        0, 0, 1,  1, 0, 8'h00, 0, 0);
    addv(1, 32'h44332211, 0, 5, 1,  1, 0, 8'h00, 0, 0);
    addv(1, 32'h88776655, 1, 6, 1,  0, 1, 8'h11, 0, 5);
    addv(1, 32'h88776655, 1, 6, 1,  0, 1, 8'h22, 0, 5);
    addv(1, 32'h88776655, 1, 6, 1,  0, 1, 8'h33, 0, 5);
    addv(1, 32'h88776655, 1, 6, 1,  1, 1, 8'h44, 0, 5);
    addv(0, 32'h0,        0, 0, 1,  0, 1, 8'h55, 0, 6);
    addv(0, 32'h0,        0, 0, 1,  0, 1, 8'h66, 0, 6);
    addv(0, 32'h0,        0, 0, 1,  0, 1, 8'h77, 0, 6);
    addv(0, 32'h0,        0, 0, 1,  1, 1, 8'h88, 1, 6);
    addv(1, 32'h44332211, 1, 2, 1,  1, 0, 8'h00, 0, 0);
    addv(0, 32'h0,        0, 0, 1,  0, 1, 8'h11, 0, 2);
    addv(0, 32'h0,        0, 0, 0,  0, 1, 8'h22, 0, 2);
    addv(0, 32'h0,        0, 0, 0,  0, 1, 8'h22, 0, 2);
    addv(0, 32'h0,        0, 0, 0,  0, 1, 8'h22, 0, 2);
    addv(0, 32'h0,        0, 0, 1,  0, 1, 8'h22, 0, 2);
    addv(0, 32'h0,        0, 0, 1,  0, 1, 8'h33, 0, 2);
    addv(0, 32'h0,        0, 0, 1,  1, 1, 8'h44, 1, 2);
    addv(1, 32'hA4A3A2A1, 0, 7, 1,  1, 0, 8'h00, 0, 0);
    addv(0, 32'h0,        0, 0, 1,  0, 1, 8'hA1, 0, 7);
    addv(0, 32'h0,        0, 0, 1,  0, 1, 8'hA2, 0, 7);
    addv(0, 32'h0,        0, 0, 1,  0, 1, 8'hA3, 0, 7);
    addv(1, 32'hB4B3B2B1, 1, 9, 0,  0, 1, 8'hA4, 0, 7);
    addv(1, 32'hB4B3B2B1, 1, 9, 1,  1, 1, 8'hA4, 0, 7);
    addv(0, 32'h0,        0, 0, 1,  0, 1, 8'hB1, 0, 9);
    addv(0, 32'h0,        0, 0, 1,  0, 1, 8'hB2, 0, 9);
    addv(0, 32'h0,        0, 0, 1,  0, 1, 8'hB3, 0, 9);
    addv(0, 32'h0,        0, 0, 1,  1, 1, 8'hB4, 1, 9);
    addv(0, 32'h0,        0, 0, 1,  1, 0, 8'h00, 0, 0);

    repeat (2) @(negedge ACLK);
    #1;
    chk("reset_a", {a_in_tready, a_out_tvalid, a_out_tlast} == 3'b100,
        64'({a_in_tready, a_out_tvalid, a_out_tlast}), 64'(3'b100));
    chk("reset_b", {b_in_tready, b_out_tvalid, b_out_tlast} == 3'b100,
        64'({b_in_tready, b_out_tvalid, b_out_tlast}), 64'(3'b100));
    @(negedge ACLK);
    ARESETn = 1'b1;

    foreach (vecs[i]) begin
      logic [14:0] act, exp;
      @(negedge ACLK);
      a_in_tvalid = vecs[i].iv; a_in_tdata = vecs[i].id; a_in_tlast = vecs[i].il;
      a_in_tdest = vecs[i].idst; a_out_tready = vecs[i].ordy;
      #1;
      act = pack_a(a_in_tready, a_out_tvalid, a_out_tlast, a_out_tdest, a_out_tdata);
      exp = pack_a(vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_ol, vecs[i].e_odst, vecs[i].e_od);
      chk($sformatf("vec[%0d]", i), act == exp, 64'(act), 64'(exp));
    end

    // Random traffic against a queue of remaining slices of the held beat.
    accepted = 0; cycles = 0; pending = 0;
    while ((accepted < 1000 || q_data.size() != 0) && cycles < 40000) begin
      @(negedge ACLK);
      cycles++;
      if (!pending) begin
        if (accepted < 1000 && $urandom_range(0, 1) == 1) begin
          a_in_tvalid = 1; a_in_tdata = $urandom; a_in_tlast = 1'($urandom_range(0, 1));
          a_in_tdest = 4'($urandom_range(0, 15));
        end else begin
          a_in_tvalid = 0;
        end
      end
      a_out_tready = 1'($urandom_range(0, 1));
      #1;
      exp_ir = (q_data.size() == 0) || (a_out_tready && q_data.size() == 1);
      chk("rand_ready_valid", {a_in_tready, a_out_tvalid} == {exp_ir, q_data.size() != 0},
          64'({a_in_tready, a_out_tvalid}), 64'({exp_ir, q_data.size() != 0}));
      if (a_out_tvalid && a_out_tready && q_data.size() != 0) begin
        chk("rand_beat", {a_out_tdata, a_out_tlast, a_out_tdest} == {q_data[0], q_last[0], q_dest[0]},
            64'({a_out_tdata, a_out_tlast, a_out_tdest}), 64'({q_data[0], q_last[0], q_dest[0]}));
        void'(q_data.pop_front()); void'(q_last.pop_front()); void'(q_dest.pop_front());
      end
      if (a_in_tvalid && a_in_tready) begin
        for (int s = 0; s < 4; s++) begin
          q_data.push_back(a_in_tdata[s*8 +: 8]);
          q_last.push_back(a_in_tlast && s == 3);
          q_dest.push_back(a_in_tdest);
        end
        accepted++;
      end
      pending = a_in_tvalid && !a_in_tready;
    end
    chk("rand_done", cycles < 40000, 64'(accepted), 64'(1000));
    @(negedge ACLK);
    a_in_tvalid = 0; a_out_tready = 1;

    // Reset after two slices have left: the rest of the beat is dropped.
    @(negedge ACLK);
    a_in_tvalid = 1; a_in_tdata = 32'h44332211; a_in_tlast = 1; a_in_tdest = 4;
    @(negedge ACLK);
    a_in_tvalid = 0;
    #1 a_expect("rst_s0", 1, 8'h11, 0, 4);
    @(negedge ACLK);
    #1 a_expect("rst_s1", 1, 8'h22, 0, 4);
    @(negedge ACLK);
    ARESETn = 1'b0;
    #1 a_expect("rst_async", 0, 8'h00, 0, 0);
    chk("rst_ready", a_in_tready == 1'b1, 64'(a_in_tready), 64'(1));
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    a_in_tvalid = 1; a_in_tdata = 32'hDDCCBBAA; a_in_tlast = 1; a_in_tdest = 1;
    @(negedge ACLK);
    a_in_tvalid = 0;
    #1 a_expect("rst_new0", 1, 8'hAA, 0, 1);
    @(negedge ACLK);
    #1 a_expect("rst_new1", 1, 8'hBB, 0, 1);
    @(negedge ACLK);
    #1 a_expect("rst_new2", 1, 8'hCC, 0, 1);
    @(negedge ACLK);
    #1 a_expect("rst_new3", 1, 8'hDD, 1, 1);

    // 1:1 configuration: pure one-cycle register slice at full rate.
    for (int k = 0; k <= 17; k++) begin
      @(negedge ACLK);
      if (k < 16) begin
        b_in_tvalid = 1; b_in_tdata = 32'h1000_0000 + 32'(k) * 32'h0101_0101;
        b_in_tlast = (k % 4 == 3); b_in_tdest = 4'(k);
      end else begin
        b_in_tvalid = 0;
      end
      #1;
      chk($sformatf("r1_ready[%0d]", k), b_in_tready == 1'b1, 64'(b_in_tready), 64'(1));
      if (k == 0 || k == 17) begin
        chk($sformatf("r1_idle[%0d]", k), !b_out_tvalid && !b_out_tlast,
            64'({b_out_tvalid, b_out_tlast}), 64'(0));
      end else begin
        beat = 32'h1000_0000 + 32'(k - 1) * 32'h0101_0101;
        chk($sformatf("r1_beat[%0d]", k),
            {b_out_tvalid, b_out_tdata, b_out_tlast, b_out_tdest} ==
            {1'b1, beat, ((k - 1) % 4 == 3), 4'(k - 1)},
            64'({b_out_tvalid, b_out_tdata, b_out_tlast, b_out_tdest}),
            64'({1'b1, beat, ((k - 1) % 4 == 3), 4'(k - 1)}));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
